// File: rtl/control_types.sv
// Shared control encodings for the load/store path.
// mem_op_t: width/sign of a data memory access; MEM_NONE is the idle encoding.
package control_types;

  typedef enum logic [2:0] {
    MEM_NONE   = 3'd0,
    MEM_BYTE   = 3'd1,
    MEM_HALF   = 3'd2,
    MEM_WORD   = 3'd3,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_t;

endpackage

// File: rtl/dmem_arb_pkg.sv
// Types for the data memory arbiter.
// arb_state_t: ST_IDLE = debug master eligible for a grant,
//              ST_ACK  = debug ack cycle, debug not eligible.
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter for the debug port.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : clear to zero (wins over inc)
//   inc         : count one lost cycle, saturating at MAX_WAIT
//   at_max      : count has reached MAX_WAIT
module arb_wait_counter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign at_max = (count_q == CNT_W'(MAX_WAIT));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Port 0 is the CPU MEM stage (priority), port 1 a debug/loader master. A starvation
// counter bounds debug latency; dbg_halt gives the debug master exclusive use.
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   cpu_req/wr_en/mem_op/addr/wdata : CPU access request
//   cpu_rdata                    : CPU load data (combinational from memory)
//   cpu_stall                    : CPU requested but not granted; MEM stage holds
//   dbg_req/wr_en/mem_op/addr/wdata : debug access, held until dbg_ack
//   dbg_halt                     : CPU never granted while high
//   dbg_rdata, dbg_ack           : registered debug read data and one-cycle ack
//   mem_*                        : muxed access towards data_memory
module dmem_arbiter
  import control_types::*;
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr_en,
  input  mem_op_t           cpu_mem_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wr_en,
  input  mem_op_t           dbg_mem_op,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_halt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_wr_en,
  output mem_op_t           mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              gnt_dbg, gnt_cpu;
  logic              wait_at_max;
  logic              wait_clr, wait_inc;

  // Grant decision and memory mux
  always_comb begin
    gnt_dbg = (state_q == ST_IDLE) && dbg_req && (dbg_halt || !cpu_req || wait_at_max);
    gnt_cpu = cpu_req && !dbg_halt && !gnt_dbg;

    mem_wr_en   = 1'b0;
    mem_op      = MEM_NONE;
    mem_addr    = '0;
    mem_data_in = '0;
    if (gnt_dbg) begin
      mem_wr_en   = dbg_wr_en;
      mem_op      = dbg_mem_op;
      mem_addr    = dbg_addr;
      mem_data_in = dbg_wdata;
    end else if (gnt_cpu) begin
      mem_wr_en   = cpu_wr_en;
      mem_op      = cpu_mem_op;
      mem_addr    = cpu_addr;
      mem_data_in = cpu_wdata;
    end
  end

  // A store either goes out whole in a granted cycle or the CPU is stalled.
  assign cpu_stall = cpu_req && !gnt_cpu;
  assign cpu_rdata = mem_data_out;

  // Next state and debug read capture
  always_comb begin
    state_d     = state_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      ST_IDLE: if (gnt_dbg) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
    endcase
    if (gnt_dbg && !dbg_wr_en) begin
      dbg_rdata_d = mem_data_out;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // The ack is exactly the ACK state, so an asynchronous reset drops it at once.
  assign dbg_ack   = (state_q == ST_ACK);
  assign dbg_rdata = dbg_rdata_q;

  // Lost cycles are counted only while the debug master is eligible; an abandoned
  // request or a grant restarts the count.
  assign wait_clr = !dbg_req || gnt_dbg;
  assign wait_inc = (state_q == ST_IDLE) && dbg_req && !gnt_dbg;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .at_max (wait_at_max)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_dmem_arbiter;
  import control_types::*;

  localparam int unsigned MW = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_wr_en;
  mem_op_t     cpu_mem_op;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_wr_en, dbg_halt;
  mem_op_t     dbg_mem_op;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic        mem_wr_en;
  mem_op_t     mem_op;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_req      (cpu_req),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_mem_op   (cpu_mem_op),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .dbg_req      (dbg_req),
    .dbg_wr_en    (dbg_wr_en),
    .dbg_mem_op   (dbg_mem_op),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_halt     (dbg_halt),
    .dbg_rdata    (dbg_rdata),
    .dbg_ack      (dbg_ack),
    .mem_wr_en    (mem_wr_en),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Stand-in data_memory: word array, combinational read, write at posedge.
  logic [31:0] mem [256] = '{default: 32'h0};
  assign mem_data_out = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[9:2]] <= mem_data_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Behavioural model: which master owns the memory this cycle, an outstanding ack,
  // the number of consecutive cycles the debug master has lost, and its own copy of memory.
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  bit          m_ack;
  int unsigned m_lost;
  logic [31:0] m_rdata;
  bit          dg, cg, was_ack;

  always @(negedge clk) begin
    if (!resetn) begin
      chk1("rst_dbg_ack", dbg_ack, 1'b0);
      chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
      m_ack   = 1'b0;
      m_lost  = 0;
      m_rdata = 32'h0;
    end else begin
      dg = !m_ack && dbg_req && (dbg_halt || !cpu_req || m_lost >= MW);
      cg = cpu_req && !dbg_halt && !dg;
      chk1("cpu_stall", cpu_stall, cpu_req && !cg);
      chk1("dbg_ack", dbg_ack, m_ack);
      chk32("dbg_rdata", dbg_rdata, m_rdata);
      if (dg) begin
        chk1("mem_wr_en_dbg", mem_wr_en, dbg_wr_en);
        chk32("mem_op_dbg", 32'(mem_op), 32'(dbg_mem_op));
        chk32("mem_addr_dbg", mem_addr, dbg_addr);
        if (dbg_wr_en) chk32("mem_data_in_dbg", mem_data_in, dbg_wdata);
      end else if (cg) begin
        chk1("mem_wr_en_cpu", mem_wr_en, cpu_wr_en);
        chk32("mem_op_cpu", 32'(mem_op), 32'(cpu_mem_op));
        chk32("mem_addr_cpu", mem_addr, cpu_addr);
        if (cpu_wr_en) chk32("mem_data_in_cpu", mem_data_in, cpu_wdata);
        else           chk32("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
      end else begin
        chk1("mem_wr_en_idle", mem_wr_en, 1'b0);
        chk32("mem_op_idle", 32'(mem_op), 32'(MEM_NONE));
      end

      was_ack = m_ack;
      m_ack   = dg;
      if (dg) begin
        if (dbg_wr_en) ref_mem[dbg_addr[9:2]] = dbg_wdata;
        else           m_rdata = ref_mem[dbg_addr[9:2]];
        m_lost = 0;
      end else if (!dbg_req) begin
        m_lost = 0;
      end else if (!was_ack && m_lost < MW) begin
        m_lost++;
      end
      if (cg && cpu_wr_en) ref_mem[cpu_addr[9:2]] = cpu_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [31:0] t5_addr [4];
  logic [31:0] t5_data [4];
  logic        was_stalled;

  initial begin
    resetn     = 1'b0;
    cpu_req    = 1'b0;
    cpu_wr_en  = 1'b0;
    cpu_mem_op = MEM_NONE;
    cpu_addr   = 32'h0;
    cpu_wdata  = 32'h0;
    dbg_req    = 1'b0;
    dbg_wr_en  = 1'b0;
    dbg_mem_op = MEM_NONE;
    dbg_addr   = 32'h0;
    dbg_wdata  = 32'h0;
    dbg_halt   = 1'b0;

    // Reset values
    neg();
    chk1("t1_dbg_ack", dbg_ack, 1'b0);
    chk32("t1_dbg_rdata", dbg_rdata, 32'h0);
    chk1("t1_mem_wr_en", mem_wr_en, 1'b0);
    chk1("t1_cpu_stall", cpu_stall, 1'b0);
    cyc();
    resetn = 1'b1;

    // CPU only: store then load
    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_mem_op = MEM_WORD;
    cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    neg();
    chk1("t2_sw_stall", cpu_stall, 1'b0);
    chk1("t2_sw_wr_en", mem_wr_en, 1'b1);
    cyc();
    cpu_wr_en = 1'b0;
    neg();
    chk1("t2_lw_stall", cpu_stall, 1'b0);
    chk32("t2_lw_rdata", cpu_rdata, 32'hDEADBEEF);
    cyc();
    cpu_req = 1'b0;

    // Debug only: write then read back
    dbg_req = 1'b1; dbg_wr_en = 1'b1; dbg_mem_op = MEM_WORD;
    dbg_addr = 32'h100; dbg_wdata = 32'h12345678;
    neg();
    chk1("t3_wr_grant", mem_wr_en, 1'b1);
    cyc();
    chk1("t3_wr_ack", dbg_ack, 1'b1);
    dbg_req = 1'b0;
    cyc();
    dbg_req = 1'b1; dbg_wr_en = 1'b0;
    cyc();
    chk1("t3_rd_ack", dbg_ack, 1'b1);
    chk32("t3_rd_data", dbg_rdata, 32'h12345678);
    dbg_req = 1'b0;
    cyc();

    // Contention: debug wins in cycle MW, acked in cycle MW+1
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h40;
    dbg_req = 1'b1; dbg_wr_en = 1'b0; dbg_addr = 32'h40;
    for (int c = 0; c < 10; c++) begin
      neg();
      chk1($sformatf("t4_stall_c%0d", c), cpu_stall, c == 8);
      if (c == 9) begin
        chk1("t4_ack", dbg_ack, 1'b1);
        chk32("t4_rdata", dbg_rdata, 32'hDEADBEEF);
      end
      cyc();
      if (c == 8) dbg_req = 1'b0;
    end
    cpu_req = 1'b0;

    // Halt: CPU store never performed, debug reads every 2 cycles
    t5_addr[0] = 32'h100; t5_data[0] = 32'h12345678;
    t5_addr[1] = 32'h40;  t5_data[1] = 32'hDEADBEEF;
    t5_addr[2] = 32'h100; t5_data[2] = 32'h12345678;
    t5_addr[3] = 32'h40;  t5_data[3] = 32'hDEADBEEF;
    dbg_halt = 1'b1;
    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hFFFFFFFF;
    dbg_req = 1'b1; dbg_wr_en = 1'b0; dbg_addr = t5_addr[0];
    for (int c = 0; c < 8; c++) begin
      neg();
      chk1($sformatf("t5_stall_c%0d", c), cpu_stall, 1'b1);
      chk1($sformatf("t5_ack_c%0d", c), dbg_ack, c % 2 == 1);
      if (c % 2 == 1) chk32($sformatf("t5_rdata_c%0d", c), dbg_rdata, t5_data[c / 2]);
      cyc();
      if (c + 1 < 8) dbg_addr = t5_addr[(c + 1) / 2];
    end
    chk32("t5_mem40", mem[16], 32'hDEADBEEF);
    dbg_halt = 1'b0;
    cpu_req  = 1'b0;
    cpu_wr_en = 1'b0;

    // Reset during the ack cycle drops the ack; re-issued read completes
    dbg_req = 1'b1; dbg_wr_en = 1'b0; dbg_addr = 32'h40;
    cyc();
    chk1("t6_ack_before", dbg_ack, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk1("t6_ack_dropped", dbg_ack, 1'b0);
    chk32("t6_rdata_reset", dbg_rdata, 32'h0);
    cyc();
    resetn = 1'b1;
    cyc();
    chk1("t6_reissue_ack", dbg_ack, 1'b1);
    chk32("t6_reissue_rdata", dbg_rdata, 32'hDEADBEEF);
    dbg_req = 1'b0;

    // Randomized traffic with compliant masters
    for (int i = 0; i < 3000; i++) begin
      neg();
      was_stalled = cpu_req && cpu_stall;
      cyc();
      if (!was_stalled) begin
        cpu_req    = ($urandom % 4) != 0;
        cpu_wr_en  = $urandom % 2;
        cpu_mem_op = mem_op_t'($urandom_range(1, 5));
        cpu_addr   = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
        cpu_wdata  = $urandom;
      end
      if (!(dbg_req && !dbg_ack) || ($urandom % 50) == 0) begin
        dbg_req    = ($urandom % 3) == 0;
        dbg_wr_en  = $urandom % 2;
        dbg_mem_op = mem_op_t'($urandom_range(1, 5));
        dbg_addr   = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
        dbg_wdata  = $urandom;
      end
      if (($urandom % 40) == 0) dbg_halt = ~dbg_halt;
    end

    neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
